// File: rtl/ram_load_store_unit.sv
// Purpose: byte/half/word load-store front end for a 4096x32 word RAM; sub-word stores use read-modify-write.
// Latency: accept to resp_valid is 1 cycle (error), 2 (word store), 3 (load), 4 (sub-word store).
// Backpressure: one request in flight; req_ready is high only in IDLE, which includes the response cycle.
`timescale 1ns/1ps
module ram_load_store_unit #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ram_a,
  output logic        ram_we,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DATA  = 2'd2,
    WR       = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              write_q, write_d;
  logic [31:0]       wd_q, wd_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  // Address bits above the RAM word index alias silently; they are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Request qualification: illegal size or misalignment is answered with an error, no RAM access.
  logic req_err;
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      SZ_ILL:  req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Load path: pick the addressed lane from the RAM word and extend it to 32 bits.
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  always_comb begin
    rd_byte  = 8'h00;
    rd_half  = 16'h0000;
    load_ext = ram_rd;
    case (addr_q[1:0])
      2'd0:    rd_byte = ram_rd[7:0];
      2'd1:    rd_byte = ram_rd[15:8];
      2'd2:    rd_byte = ram_rd[23:16];
      default: rd_byte = ram_rd[31:24];
    endcase
    rd_half = addr_q[1] ? ram_rd[31:16] : ram_rd[15:0];
    case (size_q)
      SZ_BYTE: load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default: load_ext = ram_rd;
    endcase
  end

  // Store path: replace only the addressed lane(s) of the old word with the new right-aligned data.
  logic [31:0] merged;
  always_comb begin
    merged = ram_rd;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wd_q[7:0];
        2'd1:    merged[15:8]  = wd_q[7:0];
        2'd2:    merged[23:16] = wd_q[7:0];
        default: merged[31:24] = wd_q[7:0];
      endcase
    end else if (size_q == SZ_HALF) begin
      if (addr_q[1]) merged[31:16] = wd_q[15:0];
      else           merged[15:0]  = wd_q[15:0];
    end
  end

  // Next-state and next-register logic; response flags default to a quiet cycle.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    signed_d     = signed_q;
    write_d      = write_q;
    wd_d         = wd_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr[ADDR_W+1:0];
          size_d   = req_size;
          signed_d = req_signed;
          write_d  = req_write;
          wd_d     = req_wdata;
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d = WR;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        // RAM samples ram_a at the end of this cycle.
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (write_q) begin
          wd_d    = merged;
          state_d = WR;
        end else begin
          resp_rdata_d = load_ext;
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      WR: begin
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset abandons any access in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      wd_q         <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      write_q      <= write_d;
      wd_q         <= wd_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Outputs come straight from registers so the RAM sees glitch-free address and data.
  assign req_ready  = (state_q == IDLE);
  assign ram_we     = (state_q == WR);
  assign ram_a      = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
  assign ram_wd     = wd_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_ram_load_store_unit.sv
// Bench for ram_load_store_unit with a behavioural 4096x32 RAM attached.
// Expected responses, RAM writes and read addresses are queued when a request is driven.
`timescale 1ns/1ps
module tb_ram_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] ram_a, ram_wd, ram_rd;
  logic        ram_we;

  ram_load_store_unit #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_a(ram_a), .ram_we(ram_we), .ram_wd(ram_wd), .ram_rd(ram_rd)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered read, write on ram_we.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_we) mem[ram_a[11:0]] <= ram_wd;
    ram_rd <= mem[ram_a[11:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [31:0] rdata; logic err; } resp_t;
  typedef struct { int due; logic [31:0] a; logic [31:0] wd; } wr_t;
  typedef struct { int due; logic [31:0] a; } ad_t;
  resp_t rq[$];
  wr_t   wq[$];
  ad_t   aq[$];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: every response, write and tracked address is matched against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid) begin
        if (rq.size() == 0) check_eq("resp_unexpected", 32'd1, 32'd0);
        else begin
          resp_t e;
          e = rq.pop_front();
          check_eq("resp_cycle", cyc, e.due);
          check_eq("resp_rdata", resp_rdata, e.rdata);
          check_eq("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        end
      end
      if (ram_we) begin
        if (wq.size() == 0) check_eq("we_unexpected", 32'd1, 32'd0);
        else begin
          wr_t w;
          w = wq.pop_front();
          check_eq("we_cycle", cyc, w.due);
          check_eq("we_addr", ram_a, w.a);
          check_eq("we_data", ram_wd, w.wd);
        end
      end
      if (aq.size() > 0 && aq[0].due == cyc) begin
        check_eq("rd_addr", ram_a, aq[0].a);
        void'(aq.pop_front());
      end
    end
  end

  // Drive one request (req_valid left high) and queue what it must produce.
  // lat=0 suppresses the response expectation; we_off/a_off=0 mean no write/address expectation.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat,
                        input int we_off, input logic [31:0] exp_wd, input int a_off,
                        output int n);
    logic [31:0] widx;
    int k;
    widx = {20'b0, addr[13:2]};
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check_eq("accept_timeout", 32'd0, 32'd1);
    n = cyc;
    if (lat > 0)    rq.push_back('{n + lat, exp_rd, exp_err});
    if (we_off > 0) wq.push_back('{n + we_off, widx, exp_wd});
    if (a_off > 0)  aq.push_back('{n + a_off, widx});
    @(posedge clk);
  endtask

  // Drop req_valid and wait (bounded) for all queued expectations to drain.
  task automatic finish_reqs();
    int k;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while ((rq.size() + wq.size() + aq.size()) != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check_eq("drain", rq.size() + wq.size() + aq.size(), 32'd0);
  endtask

  int n1, n2, k;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_we", {31'b0, ram_we}, 32'd0);
    check_eq("rst_ram_a", ram_a, 32'h0);
    check_eq("rst_ram_wd", ram_wd, 32'h0);
    reset = 1'b0;

    // Word store then word load.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 32'hDEADBEEF, 0, n1);
    finish_reqs();
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 32'h0, 1, n1);
    finish_reqs();

    // Byte store by read-modify-write, signed and unsigned byte loads.
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, 32'h0, 1'b0, 4, 3, 32'hDEADA5EF, 1, n1);
    finish_reqs();
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFFA5, 1'b0, 3, 0, 32'h0, 1, n1);
    finish_reqs();
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h000000A5, 1'b0, 3, 0, 32'h0, 1, n1);
    finish_reqs();

    // Half store to the upper lane, signed and unsigned half loads, full word readback.
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 32'h0, 1'b0, 4, 3, 32'h8001A5EF, 1, n1);
    finish_reqs();
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 3, 0, 32'h0, 1, n1);
    finish_reqs();
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00008001, 1'b0, 3, 0, 32'h0, 1, n1);
    finish_reqs();
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0, 32'h0, 1, n1);
    finish_reqs();
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8001A5EF, 1'b0, 3, 0, 32'h0, 1, n1);
    finish_reqs();

    // Errors: misaligned word, misaligned half, illegal size; any ram_we is flagged by the monitor.
    do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0, n1);
    finish_reqs();
    do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000FFFF, 32'h0, 1'b1, 1, 0, 32'h0, 0, n1);
    finish_reqs();
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0, n1);
    finish_reqs();

    // Reset during the write phase of a byte store: no response, RAM keeps the old word.
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000077, 32'h0, 1'b0, 0, 3, 32'h800177EF, 1, n1);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!ram_we && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_eq("wr_phase_seen", {31'b0, ram_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid_we", {31'b0, ram_we}, 32'd0);
    check_eq("rst_mid_resp", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8001A5EF, 1'b0, 3, 0, 32'h0, 1, n1);
    finish_reqs();

    // Held req_valid: aliased address, second request accepted in the first response cycle.
    do_req(1'b0, 2'b10, 1'b0, 32'h4010, 32'h0, 32'h8001A5EF, 1'b0, 3, 0, 32'h0, 1, n1);
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 3, 0, 32'h0, 1, n2);
    check_eq("b2b_accept", n2, n1 + 3);
    finish_reqs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got cycle %0d expected < 2000", cyc);
    $fatal(1);
  end

endmodule
